// File: rtl/dd_sync_filt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dd_sync_filt                                                 |
// | Description : Per-channel N-stage synchronizer followed by a stability     |
// |               (debounce) filter with runtime bypass, plus registered       |
// |               one-cycle rise/fall pulses on the filtered level.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dd_sync_filt #(
  parameter int                  SIGNAL_W         = 1,
  parameter int                  P_NO_SYNC_STAGES = 2,
  parameter int                  P_FILT_CYCLES    = 4,
  parameter logic [SIGNAL_W-1:0] P_RST_VAL        = {SIGNAL_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIGNAL_W-1:0] signal_id,
  input  logic                filt_en_id,
  output logic [SIGNAL_W-1:0] signal_od,
  output logic [SIGNAL_W-1:0] rise_pulse_od,
  output logic [SIGNAL_W-1:0] fall_pulse_od
);

  // Counter must hold 0..P_FILT_CYCLES-1; acceptance happens on the edge
  // where it already sits at the last value, so it never wraps.
  localparam int                 c_cnt_w   = $clog2(P_FILT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(P_FILT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  // Channels are fully independent: no cross-bit coherency is attempted.
  for (genvar gi = 0; gi < SIGNAL_W; gi++) begin : g_chan
    logic [P_NO_SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_level;
    logic                        r_rise;
    logic                        r_fall;
    logic                        w_sync_s;
    logic                        w_diff;

    assign w_sync_s = r_sync[P_NO_SYNC_STAGES-1];
    assign w_diff   = w_sync_s ^ r_level;

    // Shift the asynchronous level in at the LSB; MSB is the synced value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= {P_NO_SYNC_STAGES{P_RST_VAL[gi]}};
      end else begin
        r_sync <= {r_sync[P_NO_SYNC_STAGES-2:0], signal_id[gi]};
      end
    end

    // Accept a new synced level once it has held for P_FILT_CYCLES edges
    // (or immediately in bypass) and flag the resulting edge as a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_level <= P_RST_VAL[gi];
        r_cnt   <= '0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (!filt_en_id) begin
          // Bypass: a count in progress is discarded and the synced value
          // is taken as-is on this edge.
          r_cnt <= '0;
          if (w_diff) begin
            r_level <= w_sync_s;
            r_rise  <= w_sync_s;
            r_fall  <= ~w_sync_s;
          end
        end else if (!w_diff) begin
          // Level agrees with output: any partial run is a rejected glitch.
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_level <= w_sync_s;
          r_cnt   <= '0;
          r_rise  <= w_sync_s;
          r_fall  <= ~w_sync_s;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end

    assign signal_od[gi]     = r_level;
    assign rise_pulse_od[gi] = r_rise;
    assign fall_pulse_od[gi] = r_fall;
  end

endmodule
`default_nettype wire

// File: tb/tb_dd_sync_filt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dd_sync_filt                                              |
// | Description : Self-checking bench for dd_sync_filt (4 channels, reset      |
// |               value 4'b0101, default stage/filter depths).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dd_sync_filt;

  localparam int         W   = 4;
  localparam int         N   = 2;
  localparam int         F   = 4;
  localparam logic [3:0] RST = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       filt_en_id;
  logic [3:0] signal_id;
  logic [3:0] signal_od;
  logic [3:0] rise_pulse_od;
  logic [3:0] fall_pulse_od;

  int checks = 0;
  int errors = 0;

  dd_sync_filt #(
    .SIGNAL_W         (W),
    .P_NO_SYNC_STAGES (N),
    .P_FILT_CYCLES    (F),
    .P_RST_VAL        (RST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signal_id     (signal_id),
    .filt_en_id    (filt_en_id),
    .signal_od     (signal_od),
    .rise_pulse_od (rise_pulse_od),
    .fall_pulse_od (fall_pulse_od)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: remembers every input sample since reset release; the
  // filter at edge t sees the sample taken N edges earlier, and a new level
  // is accepted once it has differed from the output on F consecutive
  // enabled edges (tracked as the edge where the current run began).
  // ---------------------------------------------------------------------------
  logic [3:0] m_out  = RST;
  logic [3:0] m_rise = '0;
  logic [3:0] m_fall = '0;
  int         edge_n = 0;
  int         run_start [4];
  logic [3:0] hist [0:2047];

  initial begin
    logic [3:0] s;
    for (int i = 0; i < W; i++) run_start[i] = -1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_out  = RST;
        m_rise = '0;
        m_fall = '0;
        edge_n = 0;
        for (int i = 0; i < W; i++) run_start[i] = -1;
      end else begin
        edge_n++;
        hist[edge_n] = signal_id;
        s = (edge_n > N) ? hist[edge_n-N] : RST;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
          if (!filt_en_id || s[i] == m_out[i]) run_start[i] = -1;
          if (s[i] != m_out[i]) begin
            if (filt_en_id && run_start[i] < 0) run_start[i] = edge_n;
            if (!filt_en_id || (edge_n - run_start[i] + 1 >= F)) begin
              m_out[i]     = s[i];
              m_rise[i]    = s[i];
              m_fall[i]    = ~s[i];
              run_start[i] = -1;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_od",   signal_od,     m_out);
      chk("model_rise", rise_pulse_od, m_rise);
      chk("model_fall", fall_pulse_od, m_fall);
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    logic [3:0] acc;
    int         nrise;

    rst_n      = 1'b1;
    signal_id  = '0;
    filt_en_id = 1'b1;

    // 1: asynchronous reset, then quiet release at the reset value
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_od",   signal_od,     4'b0101);
    chk("t1_rst_rise", rise_pulse_od, 4'b0000);
    chk("t1_rst_fall", fall_pulse_od, 4'b0000);
    repeat (2) @(negedge clk);
    signal_id = 4'b0101;
    rst_n     = 1'b1;
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc |= rise_pulse_od | fall_pulse_od;
    end
    chk("t1_no_pulse", acc, 4'b0000);
    chk("t1_od", signal_od, 4'b0101);

    // bring every channel to 0 through the normal path
    signal_id = 4'b0000;
    repeat (10) @(negedge clk);
    chk("prep_od", signal_od, 4'b0000);

    // 2: filtered latency N+F = 6 edges for rise and fall
    signal_id = 4'b0001;
    repeat (5) @(negedge clk);
    chk("t2_od_e5",   signal_od,     4'b0000);
    chk("t2_rise_e5", rise_pulse_od, 4'b0000);
    @(negedge clk);
    chk("t2_od_e6",   signal_od,     4'b0001);
    chk("t2_rise_e6", rise_pulse_od, 4'b0001);
    @(negedge clk);
    chk("t2_rise_e7", rise_pulse_od, 4'b0000);
    signal_id = 4'b0000;
    repeat (5) @(negedge clk);
    chk("t2_fall_e5", fall_pulse_od, 4'b0000);
    @(negedge clk);
    chk("t2_fall_e6", fall_pulse_od, 4'b0001);
    chk("t2_od_low",  signal_od,     4'b0000);

    // 3: 3-cycle glitch rejected, then a held level accepted once
    signal_id = 4'b0010;
    repeat (3) @(negedge clk);
    signal_id = 4'b0000;
    acc = '0;
    repeat (10) begin
      @(negedge clk);
      acc |= signal_od | rise_pulse_od | fall_pulse_od;
    end
    chk("t3_glitch", acc, 4'b0000);
    signal_id = 4'b0010;
    nrise = 0;
    repeat (5) begin
      @(negedge clk);
      nrise += int'(rise_pulse_od[1]);
    end
    chk("t3_od_e5", signal_od, 4'b0000);
    @(negedge clk);
    nrise += int'(rise_pulse_od[1]);
    chk("t3_od_e6",   signal_od,     4'b0010);
    chk("t3_rise_e6", rise_pulse_od, 4'b0010);
    repeat (6) begin
      @(negedge clk);
      nrise += int'(rise_pulse_od[1]);
    end
    chk("t3_one_rise", 4'(nrise), 4'd1);
    signal_id = 4'b0000;
    repeat (8) @(negedge clk);

    // 4: bypass passes a 1-cycle pulse after N+1 edges
    filt_en_id = 1'b0;
    repeat (2) @(negedge clk);
    signal_id = 4'b0100;
    @(negedge clk);
    signal_id = 4'b0000;
    @(negedge clk);
    chk("t4_od_e2", signal_od, 4'b0000);
    @(negedge clk);
    chk("t4_od_e3",   signal_od,     4'b0100);
    chk("t4_rise_e3", rise_pulse_od, 4'b0100);
    @(negedge clk);
    chk("t4_od_e4",   signal_od,     4'b0000);
    chk("t4_fall_e4", fall_pulse_od, 4'b0100);
    chk("t4_rise_e4", rise_pulse_od, 4'b0000);
    filt_en_id = 1'b1;
    repeat (4) @(negedge clk);

    // 5: simultaneous rise on bit 0 and fall on bit 3
    signal_id = 4'b1000;
    repeat (8) @(negedge clk);
    chk("t5_prep", signal_od, 4'b1000);
    signal_id = 4'b0001;
    repeat (5) @(negedge clk);
    chk("t5_od_e5", signal_od, 4'b1000);
    @(negedge clk);
    chk("t5_od_e6",   signal_od,     4'b0001);
    chk("t5_rise_e6", rise_pulse_od, 4'b0001);
    chk("t5_fall_e6", fall_pulse_od, 4'b1000);

    // 6a: reset asserted while bit 1 is mid-count
    signal_id = 4'b0011;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6a_rst_od",   signal_od,     4'b0101);
    chk("t6a_rst_rise", rise_pulse_od, 4'b0000);
    chk("t6a_rst_fall", fall_pulse_od, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6a_after_od", signal_od, 4'b0011);

    // 6b: bypass entered at counter=2 takes the pending value next edge
    signal_id = 4'b0111;
    repeat (4) @(negedge clk);
    chk("t6b_od_e4", signal_od, 4'b0011);
    filt_en_id = 1'b0;
    @(negedge clk);
    chk("t6b_od_e5",   signal_od,     4'b0111);
    chk("t6b_rise_e5", rise_pulse_od, 4'b0100);
    @(negedge clk);
    chk("t6b_rise_e6", rise_pulse_od, 4'b0000);
    filt_en_id = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
